// File: rtl/bcd_pkg.sv
// Shared encodings and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int                   BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_CORR   = 4'd3;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a digit that picked up a shifted-in
// 8 (worth 5 in the digit below) is pulled back by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= ADJ_THRESH) ? digit - ADJ_CORR : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: alternating right shifts and
// per-digit adjusts over a {bcd, bin} work register.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]               bin_d_out,
  output logic                           rdy,
  output logic                           busy,
  output logic                           err
);

  localparam int BCD_W  = BCD_DIGIT_W * NDIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  state_t             state, state_nxt;
  logic [WORK_W-1:0]  work;
  logic [CNT_W-1:0]   cnt;
  logic               bad_q;
  logic [NDIGITS-1:0] nib_bad;
  logic [BCD_W-1:0]   bcd_adj;
  logic               bad_in, last_shift;
  logic               load, step, adjust, finish;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    assign nib_bad[g] = bcd_d_in[g*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX;
    bcd_digit_adjust u_adj (
      .digit   (work[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted(bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign bad_in     = |nib_bad;
  assign last_shift = (cnt == LAST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = bad_in ? DONE : SHIFT;
      SHIFT:   state_nxt = last_shift ? DONE : ADJUST;
      ADJUST:  state_nxt = SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && en;
    step   = (state == SHIFT);
    adjust = (state == ADJUST);
    finish = (state == DONE);
  end

  // Results only move on the DONE edge, so intermediate work never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      bad_q     <= 1'b0;
      bin_d_out <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy <= finish;
      if (load) begin
        work  <= {bcd_d_in, {BIN_W{1'b0}}};
        cnt   <= '0;
        bad_q <= bad_in;
        busy  <= 1'b1;
      end
      if (step) begin
        work <= work >> 1;
        cnt  <= last_shift ? '0 : cnt + CNT_W'(1);
      end
      if (adjust) work[WORK_W-1:BIN_W] <= bcd_adj;
      if (finish) begin
        busy      <= 1'b0;
        err       <= bad_q;
        bin_d_out <= bad_q ? '0 : work[BIN_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin with default parameters (4 digits, 14-bit result).
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] bcd_d_in;
  logic [13:0] bin_d_out;
  logic        rdy, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin #(.NDIGITS(4), .BIN_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bcd_d_in (bcd_d_in),
    .bin_d_out(bin_d_out),
    .rdy      (rdy),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Starts a conversion and returns after rdy (or after a 100-cycle bound).
  task automatic run_conv(input logic [15:0] val, output logic [13:0] bin,
                          output logic e, output int lat, output int bcnt);
    @(negedge clk); en = 1'b1; bcd_d_in = val;
    @(negedge clk); en = 1'b0;
    lat = 0; bcnt = 0;
    while (rdy !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk); lat++;
    end
    bin = bin_d_out; e = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bcd_d_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bin_d_out, rdy, busy, err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bin=%0d rdy=%b busy=%b err=%b, want all 0",
               bin_d_out, rdy, busy, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [13:0] b; logic e; int lat, bc;
    run_conv(16'h0000, b, e, lat, bc);
    n_checks++;
    if (lat != 28) begin n_fail++; $display("FAIL zero_latency: got %0d want 28", lat); end
    n_checks++;
    if (b !== 14'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL zero_value: got bin=%0d err=%b want 0/0", b, e);
    end
    n_checks++;
    if (bc != 28 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: got busy cycles=%0d busy_at_rdy=%b want 28/0", bc, busy);
    end
    @(negedge clk);
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse: got rdy=%b one cycle later want 0", rdy); end
  endtask

  task automatic test_max_values();
    logic [13:0] b; logic e; int lat, bc;
    run_conv(16'h9999, b, e, lat, bc);
    n_checks++;
    if (b !== 14'h270F || e !== 1'b0 || lat != 28) begin
      n_fail++; $display("FAIL conv_9999: got bin=%0d err=%b lat=%0d want 9999/0/28", b, e, lat);
    end
    run_conv(16'h4095, b, e, lat, bc);
    n_checks++;
    if (b !== 14'h0FFF || e !== 1'b0 || lat != 28) begin
      n_fail++; $display("FAIL conv_4095: got bin=%0d err=%b lat=%0d want 4095/0/28", b, e, lat);
    end
  endtask

  task automatic test_roundtrip();
    logic [13:0] b; logic e; int lat, bc;
    for (int v = 0; v <= 4095; v += 13) begin
      run_conv(to_bcd(v), b, e, lat, bc);
      n_checks++;
      if (b !== 14'(v) || e !== 1'b0 || lat != 28) begin
        n_fail++; $display("FAIL roundtrip_%0d: got bin=%0d err=%b lat=%0d", v, b, e, lat);
      end
    end
  endtask

  task automatic test_bad_nibble();
    logic [13:0] b; logic e; int lat, bc;
    run_conv(16'h12A4, b, e, lat, bc);
    n_checks++;
    if (b !== 14'd0 || e !== 1'b1 || lat != 1) begin
      n_fail++; $display("FAIL bad_12A4: got bin=%0d err=%b lat=%0d want 0/1/1", b, e, lat);
    end
    run_conv(16'h0042, b, e, lat, bc);
    n_checks++;
    if (b !== 14'd42 || e !== 1'b0 || lat != 28) begin
      n_fail++; $display("FAIL after_bad_0042: got bin=%0d err=%b lat=%0d want 42/0/28", b, e, lat);
    end
    run_conv(16'hF000, b, e, lat, bc);
    n_checks++;
    if (b !== 14'd0 || e !== 1'b1 || lat != 1) begin
      n_fail++; $display("FAIL bad_F000: got bin=%0d err=%b lat=%0d want 0/1/1", b, e, lat);
    end
  endtask

  task automatic test_busy_ignore();
    int n, extra;
    @(negedge clk); en = 1'b1; bcd_d_in = 16'h1234;
    @(negedge clk); en = 1'b0;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      en = (n == 4 || n == 26); bcd_d_in = en ? 16'h5678 : 16'h1234;
      @(negedge clk); n++;
    end
    en = 1'b0;
    n_checks++;
    if (bin_d_out !== 14'd1234 || n != 28) begin
      n_fail++; $display("FAIL busy_ignore: got bin=%0d lat=%0d want 1234/28", bin_d_out, n);
    end
    extra = 0;
    repeat (35) begin
      @(negedge clk);
      if (rdy === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL no_second_rdy: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] b; logic e; int lat, bc, n;
    run_conv(16'h1234, b, e, lat, bc);
    en = 1'b1; bcd_d_in = 16'h0007;
    @(negedge clk); en = 1'b0;
    n = 1;
    while (rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (bin_d_out !== 14'd7 || err !== 1'b0 || n != 29) begin
      n_fail++; $display("FAIL back_to_back: got bin=%0d err=%b gap=%0d want 7/0/29", bin_d_out, err, n);
    end
  endtask

  task automatic test_rst_mid();
    logic [13:0] b; logic e; int lat, bc, extra;
    @(negedge clk); en = 1'b1; bcd_d_in = 16'h8888;
    @(negedge clk); en = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if ({bin_d_out, rdy, busy, err} !== 17'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got bin=%0d rdy=%b busy=%b err=%b, want all 0",
               bin_d_out, rdy, busy, err);
    end
    extra = 0;
    repeat (35) begin @(negedge clk); if (rdy === 1'b1) extra++; end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL rst_mid_no_rdy: got %0d rdy cycles want 0", extra); end
    run_conv(16'h0001, b, e, lat, bc);
    n_checks++;
    if (b !== 14'd1 || e !== 1'b0 || lat != 28) begin
      n_fail++; $display("FAIL after_rst_0001: got bin=%0d err=%b lat=%0d want 1/0/28", b, e, lat);
    end
  endtask

  task automatic test_rst_en();
    int active;
    @(negedge clk); rst = 1'b1; en = 1'b1; bcd_d_in = 16'h0005;
    @(negedge clk); rst = 1'b0; en = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_en_busy: got busy=%b rdy=%b want 0/0", busy, rdy);
    end
    active = 0;
    repeat (35) begin @(negedge clk); if (rdy === 1'b1 || busy === 1'b1) active++; end
    n_checks++;
    if (active != 0) begin n_fail++; $display("FAIL rst_en_idle: got %0d active cycles want 0", active); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bcd_d_in = '0;
    test_reset();
    test_zero();
    test_max_values();
    test_bad_nibble();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
    test_rst_en();
    test_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from every BCD digit ≥ 8). It is the decode partner of the existing binary-to-BCD encoder. It turns a 4-digit packed BCD value (for example, one entered on the keypad or switches) back into a binary number for the arithmetic datapath. It uses the same one-cycle `en` start and one-cycle `rdy` completion pulse as the encoder, and it flags any input nibble that is not a valid decimal digit.

## Interface
- `NDIGITS`, default 4: number of packed BCD digits.
- `BIN_W`, default 14: output width. Must satisfy 10^NDIGITS − 1 < 2^BIN_W.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: start request; sampled only when `busy`=0.
- `bcd_d_in`  in  4*NDIGITS: packed BCD, digit 0 in bits [3:0].
- `bin_d_out`  out  BIN_W: registered result; holds its value until the next completion.
- `rdy`  out  1: one-cycle pulse when `bin_d_out` and `err` are updated.
- `busy`  out  1: high from the accept edge until the completion edge.
- `err`  out  1: registered; 1 if the last accepted input had any nibble > 9.

## Operation
- Reset values: `bin_d_out`=0, `rdy`=0, `busy`=0, `err`=0. Internal state is IDLE, shift counter is 0, work register is 0.
- Work register is {bcd field (4*NDIGITS bits), bin field (BIN_W bits)}.
- States and transitions:
  - IDLE: if `en`, load the work register with {`bcd_d_in`, 0} and set `busy`. Go to DONE if any nibble > 9, otherwise go to SHIFT.
  - SHIFT: logical right shift of the whole work register by 1 and increment the counter. If counter == BIN_W−1, clear the counter and go to DONE; otherwise go to ADJUST.
  - ADJUST: every digit of the bcd field that is ≥ 8 has 3 subtracted. All digits are adjusted in parallel, per-nibble with no borrow between nibbles. Then go to SHIFT.
  - DONE:
    - On a valid conversion, `bin_d_out` takes the bin field and `err` is cleared.
    - On an invalid input, `bin_d_out` is set to 0 and `err` is set.
    - In both cases `rdy`=1, `busy`=0, and the state returns to IDLE.
- `rdy` is cleared on every edge at which the state is not DONE.
- `en` while `busy`=1 is ignored; there is no queuing, and `bcd_d_in` is not resampled.
- `bin_d_out` and `err` never show intermediate values.
- `rst` mid-conversion aborts immediately to reset values; any partial result is discarded.
- An illegal state encoding goes to IDLE.

## Timing
- Accept edge E0 is the edge at which `en`=1 in IDLE. `busy`=1 after E0.
- Valid input:
  - BIN_W shifts and BIN_W−1 adjusts run at E1 through E(2·BIN_W−1).
  - DONE executes at E(2·BIN_W): `rdy` is high for E28–E29 with the defaults, so latency is 28 cycles.
- Invalid input: DONE executes at E1, so `rdy` is high after E1 (latency 1 cycle).
- `busy` falls on the same edge that `rdy` rises.
- `en` asserted in the `rdy` cycle is accepted at the next edge, so back-to-back conversions cost 2·BIN_W+1 cycles each.
- Simultaneous `rst` and `en`: reset wins.

## Structure
- Package `bcd_pkg` contains:
  - the state encoding IDLE/SHIFT/ADJUST/DONE;
  - `BCD_DIGIT_W`=4;
  - the adjust constants (threshold 8, correction 3);
  - the valid-digit maximum 9.
- Sub-module `bcd_digit_adjust` is combinational: a 4-bit digit in, and a 4-bit digit out, with 3 subtracted if the input is ≥ 8. It is instantiated NDIGITS times with a generate loop.
- All remaining logic (FSM, counter, work register) lives in the top level.

## Test plan
- `bcd_d_in`=0x0000, `en` pulse: `rdy` rises exactly 28 cycles after the accept edge, `bin_d_out`=0, `err`=0, and `busy` is high for 28 cycles.
- 0x9999: `bin_d_out`=9999 (0x270F), `err`=0. Then 0x4095 gives 4095 (0x0FFF). Round-trip all values 0..4095 through the existing encoder and require identity.
- 0x12A4 (bad nibble A): `rdy` 1 cycle after accept, `bin_d_out`=0, `err`=1. A following 0x0042 gives 42 with `err`=0.
- Start 0x1234, then pulse `en` with 0x5678 at cycles 5 and 27 after accept: result is 1234 and no second `rdy` follows. Then `en` in the `rdy` cycle with 0x0007 gives 7, 29 cycles after the first `rdy`.
- `rst` for 1 cycle at cycle 10 of a 0x8888 conversion: all outputs are 0 on the next edge and no `rdy` appears. A following `en` with 0x0001 gives 1 after 28 cycles.
- `rst` and `en` high in the same cycle: remain IDLE, `busy`=0, `rdy` never asserts.
